// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes diff = a - b LSB-first, one bit per clock,
// with a single borrow flip-flop, a start/busy/done handshake and borrow/overflow flags.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] ra, ra_n;
    logic [WIDTH-1:0] rb, rb_n;
    logic [WIDTH-1:0] diff_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             borrow, borrow_n;
    logic             sa, sa_n;
    logic             sb, sb_n;
    logic             busy_n, done_n, bout_n, ovf_n;
    logic             d, b_next;

    // Full-subtractor cell on the current LSBs.
    assign d      = ra[0] ^ rb[0] ^ borrow;
    assign b_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow);

    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    always_comb begin
        state_n  = state;
        ra_n     = ra;
        rb_n     = rb;
        diff_n   = diff;
        cnt_n    = cnt;
        borrow_n = borrow;
        sa_n     = sa;
        sb_n     = sb;
        busy_n   = busy;
        done_n   = 1'b0;
        bout_n   = bout;
        ovf_n    = ovf;

        case (state)
            IDLE: begin
                if (start) begin
                    ra_n     = a;
                    rb_n     = b;
                    borrow_n = 1'b0;
                    cnt_n    = '0;
                    sa_n     = a[WIDTH-1];
                    sb_n     = b[WIDTH-1];
                    busy_n   = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                diff_n   = {d, diff[WIDTH-1:1]};
                borrow_n = b_next;
                ra_n     = ra >> 1;
                rb_n     = rb >> 1;
                cnt_n    = cnt + CW'(1);
                if (cnt == LAST) begin
                    // The last bit shifted in is the sign bit of the result.
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    bout_n  = b_next;
                    ovf_n   = (sa != sb) & (d != sa);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            diff   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_n;
            ra     <= ra_n;
            rb     <= rb_n;
            diff   <= diff_n;
            cnt    <= cnt_n;
            borrow <= borrow_n;
            sa     <= sa_n;
            sb     <= sb_n;
            busy   <= busy_n;
            done   <= done_n;
            bout   <= bout_n;
            ovf    <= ovf_n;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: an 8-bit and a 4-bit instance compared every cycle against an
// arithmetic model of the handshake timing and of a - b, plus literal directed expectations.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] diff4;

    int checks   = 0;
    int failures = 0;

    // Model state per instance (0 = WIDTH 8, 1 = WIDTH 4).
    int m_left[2];
    int m_done[2];
    int m_diff[2], m_bout[2], m_ovf[2];
    int p_diff[2], p_bout[2], p_ovf[2];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int width_of(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    // Reference arithmetic: a - b in plain integers.
    task automatic ref_sub(input int w, input int av, input int bv,
                           output int d, output int bo, output int ov);
        int sav, sbv, s;
        d   = (av - bv) & ((1 << w) - 1);
        bo  = (av < bv) ? 1 : 0;
        sav = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sbv = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        s   = sav - sbv;
        ov  = (s < -(1 << (w - 1)) || s >= (1 << (w - 1))) ? 1 : 0;
    endtask

    // Timing model: an accepted op keeps the block busy for WIDTH edges, then done for one cycle.
    task automatic model_step(input int i, input logic r, input logic s, input int av, input int bv);
        if (r) begin
            m_left[i] = 0;
            m_done[i] = 0;
            m_diff[i] = 0;
            m_bout[i] = 0;
            m_ovf[i]  = 0;
        end else if (m_left[i] == 0) begin
            m_done[i] = 0;
            if (s) begin
                ref_sub(width_of(i), av, bv, p_diff[i], p_bout[i], p_ovf[i]);
                m_left[i] = width_of(i);
            end
        end else begin
            m_left[i]--;
            m_done[i] = 0;
            if (m_left[i] == 0) begin
                m_done[i] = 1;
                m_diff[i] = p_diff[i];
                m_bout[i] = p_bout[i];
                m_ovf[i]  = p_ovf[i];
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step(0, rst, start8, int'(a8), int'(b8));
    always @(posedge clk or posedge rst) model_step(1, rst, start4, int'(a4), int'(b4));

    task automatic check_inst(input int i, input logic bz, input logic dn,
                              input int df, input logic bo, input logic ov);
        string t;
        t = (i == 0) ? "w8" : "w4";
        check({t, "_busy"}, 32'(bz), 32'(m_left[i] != 0));
        check({t, "_done"}, 32'(dn), 32'(m_done[i]));
        if (m_left[i] == 0) begin
            check({t, "_diff"}, 32'(df), 32'(m_diff[i]));
            check({t, "_bout"}, 32'(bo), 32'(m_bout[i]));
            check({t, "_ovf"},  32'(ov), 32'(m_ovf[i]));
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, busy8, done8, int'(diff8), bout8, ovf8);
        check_inst(1, busy4, done4, int'(diff4), bout4, ovf4);
    end

    // Waits (bounded) for done8, counting negedges after the accepting edge.
    task automatic wait_done8(input string nm, output int k);
        k = 0;
        while (!done8 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_latency"}, 32'(k), 32'd8);
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                        input logic eb, input logic eo, input string nm);
        int k;
        @(negedge clk);
        start8 = 1'b1;
        a8 = av;
        b8 = bv;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        wait_done8(nm, k);
        check({nm, "_diff"}, 32'(diff8), 32'(ed));
        check({nm, "_bout"}, 32'(bout8), 32'(eb));
        check({nm, "_ovf"},  32'(ovf8),  32'(eo));
    endtask

    initial begin
        int k;
        repeat (2) @(negedge clk);
        check("reset_diff", 32'(diff8), 32'd0);
        check("reset_busy", 32'(busy8), 32'd0);
        check("reset_done", 32'(done8), 32'd0);
        rst = 1'b0;

        run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub_5_3");
        run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_3_5");
        run8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_1");
        run8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "sub_0_0");
        run8(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "sub_0_ff");

        // Back-to-back with start held high and operands changing mid-operation.
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'h10;
        b8 = 8'h01;
        @(negedge clk);
        a8 = 8'h20;
        wait_done8("b2b_first", k);
        check("b2b_first_diff", 32'(diff8), 32'h0F);
        @(negedge clk);
        check("b2b_nogap_busy", 32'(busy8), 32'd1);
        check("b2b_nogap_done", 32'(done8), 32'd0);
        start8 = 1'b0;
        a8 = 8'h55;
        b8 = 8'h77;
        wait_done8("b2b_second", k);
        check("b2b_second_diff", 32'(diff8), 32'h1F);
        check("b2b_second_ovf", 32'(ovf8), 32'd0);

        // Asynchronous reset shortly after edge E4 of an operation.
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h33;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_diff", 32'(diff8), 32'd0);
        check("async_rst_busy", 32'(busy8), 32'd0);
        check("async_rst_done", 32'(done8), 32'd0);
        check("async_rst_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no_done_after_rst", 32'(done8), 32'd0);
        run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "after_rst");

        // Randomized traffic on the 8-bit instance; the compare process checks each cycle.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start8 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Exhaustive sweep on the 4-bit instance.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                start4 = 1'b1;
                a4 = 4'(x);
                b4 = 4'(y);
                @(negedge clk);
                start4 = 1'b0;
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                k = 0;
                while (!done4 && k < 12) begin
                    @(negedge clk);
                    k++;
                end
                if (k != 4) check("w4_latency", 32'(k), 32'd4);
            end
        end
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
